// File: rtl/hyperram_seq_if.sv
// Request, write/read data and PHY-facing signals of the HyperRAM sequencer.
// The master side is the requester plus the PHY; the slave side is the sequencer.
interface hyperram_seq_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_reg;
    logic        req_wrap;
    logic [21:0] req_addr;
    logic [7:0]  req_len;
    logic [15:0] wdata;
    logic [1:0]  wmask;
    logic        wdata_ready;
    logic [15:0] rdata;
    logic        rdata_valid;
    logic        done;
    logic        err;
    logic        cs_n;
    logic        ck_en;
    logic [15:0] dq_out;
    logic        dq_oe;
    logic [1:0]  rwds_out;
    logic        rwds_oe;
    logic        rwds_in;
    logic [15:0] dq_in;
    logic        dq_in_valid;

    modport master (
        output req_valid, req_write, req_reg, req_wrap, req_addr, req_len,
               wdata, wmask, rwds_in, dq_in, dq_in_valid,
        input  req_ready, wdata_ready, rdata, rdata_valid, done, err,
               cs_n, ck_en, dq_out, dq_oe, rwds_out, rwds_oe
    );

    modport slave (
        input  req_valid, req_write, req_reg, req_wrap, req_addr, req_len,
               wdata, wmask, rwds_in, dq_in, dq_in_valid,
        output req_ready, wdata_ready, rdata, rdata_valid, done, err,
               cs_n, ck_en, dq_out, dq_oe, rwds_out, rwds_oe
    );
endinterface

// File: rtl/hyperram_seq.sv
// HyperRAM (S27KL0642) transaction sequencer: turns one request into a full
// HyperBus transaction (CA, initial latency, data burst, CS# recovery).
// One clk equals one HyperBus CK cycle carrying one 16-bit word.
module hyperram_seq #(
    parameter int LATENCY    = 6,
    parameter int T_RWR      = 3,
    parameter int RD_TIMEOUT = 64
) (
    input logic           clk,
    input logic           rst,
    hyperram_seq_if.slave bus
);
    localparam int RW = (T_RWR > 1) ? $clog2(T_RWR) : 1;
    localparam int TW = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
    localparam logic [4:0]    LAT_ONE = 5'(LATENCY - 1);
    localparam logic [4:0]    LAT_TWO = 5'(2 * LATENCY - 1);
    localparam logic [RW-1:0] RWR_LD  = RW'(T_RWR - 1);
    localparam logic [TW-1:0] TO_LAST = TW'(RD_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_CA0, ST_CA1, ST_CA2, ST_LAT, ST_WDATA, ST_RDATA, ST_END
    } state_t;

    state_t        state;
    logic [47:0]   ca;
    logic [47:0]   ca_next;
    logic          is_write;
    logic          is_reg;
    logic          accept;
    logic [4:0]    lcnt;
    logic [8:0]    wcnt;
    logic [TW-1:0] tcnt;
    logic [RW-1:0] rcnt;
    logic          req_ready;
    logic          wdata_ready;
    logic          rdata_valid;
    logic          done;
    logic          err;
    logic          cs_n;
    logic          ck_en;
    logic          dq_oe;
    logic          rwds_oe;
    logic [15:0]   dq_q;
    logic [15:0]   rdata;

    // Command/address word: R/W#, address space, burst type, row/column split.
    assign ca_next = {~bus.req_write, bus.req_reg, ~bus.req_wrap, 10'd0,
                      bus.req_addr[21:3], 13'd0, bus.req_addr[2:0]};
    assign accept  = req_ready & bus.req_valid;

    // Request fields held for the whole transaction.
    // NOTE: pure datapath registers only read under FSM qualification, so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            ca       <= ca_next;
            is_write <= bus.req_write;
            is_reg   <= bus.req_reg;
        end
    end

    // Read word capture; consumers only look at it while rdata_valid is high.
    always_ff @(posedge clk) begin
        if (state == ST_RDATA && bus.dq_in_valid) begin
            rdata <= bus.dq_in;
        end
    end

    // Transaction FSM with registered bus controls and one-cycle pulses.
    // NOTE: every state and output register here uses non-blocking assignment so all see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_END;
            rcnt        <= RWR_LD;
            lcnt        <= '0;
            wcnt        <= '0;
            tcnt        <= '0;
            cs_n        <= 1'b1;
            ck_en       <= 1'b0;
            dq_oe       <= 1'b0;
            rwds_oe     <= 1'b0;
            req_ready   <= 1'b0;
            wdata_ready <= 1'b0;
            rdata_valid <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            dq_q        <= '0;
        end else begin
            rdata_valid <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state     <= ST_CA0;
                        req_ready <= 1'b0;
                        cs_n      <= 1'b0;
                        ck_en     <= 1'b1;
                        dq_oe     <= 1'b1;
                        dq_q      <= ca_next[47:32];
                        wcnt      <= (bus.req_len == 8'd0) ? 9'd256 : {1'b0, bus.req_len};
                    end
                end
                ST_CA0: begin
                    state <= ST_CA1;
                    dq_q  <= ca[31:16];
                end
                ST_CA1: begin
                    state <= ST_CA2;
                    dq_q  <= ca[15:0];
                end
                ST_CA2: begin
                    dq_q <= '0;
                    if (is_write && is_reg) begin
                        // Register writes carry a single word with no latency.
                        state       <= ST_WDATA;
                        wcnt        <= 9'd1;
                        wdata_ready <= 1'b1;
                        rwds_oe     <= 1'b0;
                    end else begin
                        // RWDS high during CA asks for doubled initial latency.
                        state <= ST_LAT;
                        dq_oe <= 1'b0;
                        lcnt  <= bus.rwds_in ? LAT_TWO : LAT_ONE;
                    end
                end
                ST_LAT: begin
                    if (lcnt == 5'd0) begin
                        if (is_write) begin
                            state       <= ST_WDATA;
                            wdata_ready <= 1'b1;
                            dq_oe       <= 1'b1;
                            rwds_oe     <= ~is_reg;
                        end else begin
                            state <= ST_RDATA;
                            tcnt  <= '0;
                        end
                    end else begin
                        lcnt <= lcnt - 5'd1;
                    end
                end
                ST_WDATA: begin
                    if (wcnt == 9'd1) begin
                        state       <= ST_END;
                        rcnt        <= RWR_LD;
                        cs_n        <= 1'b1;
                        ck_en       <= 1'b0;
                        dq_oe       <= 1'b0;
                        rwds_oe     <= 1'b0;
                        wdata_ready <= 1'b0;
                        done        <= 1'b1;
                    end else begin
                        wcnt <= wcnt - 9'd1;
                    end
                end
                ST_RDATA: begin
                    if (bus.dq_in_valid) begin
                        rdata_valid <= 1'b1;
                        wcnt        <= wcnt - 9'd1;
                        tcnt        <= '0;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                    if ((bus.dq_in_valid && wcnt == 9'd1) ||
                        (!bus.dq_in_valid && tcnt == TO_LAST)) begin
                        state <= ST_END;
                        rcnt  <= RWR_LD;
                        cs_n  <= 1'b1;
                        ck_en <= 1'b0;
                        done  <= 1'b1;
                        err   <= ~bus.dq_in_valid;
                    end
                end
                ST_END: begin
                    if (rcnt == '0) begin
                        state     <= ST_IDLE;
                        req_ready <= 1'b1;
                    end else begin
                        rcnt <= rcnt - 1'b1;
                    end
                end
                default: state <= ST_END;
            endcase
        end
    end

    // Write words pass straight through to the PHY in the cycle they are consumed.
    assign bus.dq_out      = wdata_ready ? bus.wdata : dq_q;
    assign bus.rwds_out    = rwds_oe ? bus.wmask : 2'b00;
    assign bus.req_ready   = req_ready;
    assign bus.wdata_ready = wdata_ready;
    assign bus.rdata       = rdata;
    assign bus.rdata_valid = rdata_valid;
    assign bus.done        = done;
    assign bus.err         = err;
    assign bus.cs_n        = cs_n;
    assign bus.ck_en       = ck_en;
    assign bus.dq_oe       = dq_oe;
    assign bus.rwds_oe     = rwds_oe;
endmodule

// File: tb/tb_hyperram_seq.sv
// Self-checking bench for hyperram_seq: directed scenarios plus randomized
// transactions checked cycle by cycle against a timeline model of the bus.
module tb_hyperram_seq;
    localparam int LATENCY    = 6;
    localparam int T_RWR      = 3;
    localparam int RD_TIMEOUT = 64;
    localparam int MAXC       = 2048;

    logic clk = 1'b0;
    logic rst;
    hyperram_seq_if bus();

    hyperram_seq #(
        .LATENCY(LATENCY), .T_RWR(T_RWR), .RD_TIMEOUT(RD_TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Per-cycle stimulus of the current transaction, indexed by cycle after acceptance.
    logic [15:0] wd  [MAXC];
    logic [1:0]  wm  [MAXC];
    logic [15:0] din [MAXC];
    bit          vpat[$];

    task automatic fill_random();
        for (int i = 0; i < MAXC; i++) begin
            wd[i]  = 16'($urandom);
            wm[i]  = 2'($urandom);
            din[i] = 16'($urandom);
        end
    endtask

    function automatic bit vbit(int k);
        return (k < vpat.size()) ? vpat[k] : 1'b0;
    endfunction

    // Read-return pattern: each word preceded by 0..maxgap silent cycles.
    task automatic make_reads(input int words, input int maxgap);
        vpat.delete();
        for (int w = 0; w < words; w++) begin
            int gap;
            gap = $urandom_range(0, maxgap);
            repeat (gap) vpat.push_back(1'b0);
            vpat.push_back(1'b1);
        end
    endtask

    task automatic idle_inputs();
        bus.req_valid   = 1'b0;
        bus.req_write   = 1'b0;
        bus.req_reg     = 1'b0;
        bus.req_wrap    = 1'b0;
        bus.req_addr    = '0;
        bus.req_len     = '0;
        bus.wdata       = '0;
        bus.wmask       = '0;
        bus.rwds_in     = 1'b0;
        bus.dq_in       = '0;
        bus.dq_in_valid = 1'b0;
    endtask

    task automatic start_req(input bit wr, input bit rg, input bit wp, input logic [21:0] addr,
                             input logic [7:0] len, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 32 && !ok; i++) begin
            @(negedge clk);
            #1;
            if (bus.req_ready === 1'b1) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL req_ready_wait: req_ready=%b after 32 cycles, required 1", bus.req_ready);
        end else begin
            bus.req_valid = 1'b1;
            bus.req_write = wr;
            bus.req_reg   = rg;
            bus.req_wrap  = wp;
            bus.req_addr  = addr;
            bus.req_len   = len;
        end
    endtask

    // One full transaction, compared every cycle against the bus timeline:
    // 3 CA cycles, N latency cycles, data phase, then T_RWR recovery cycles.
    task automatic run_txn(input bit wr, input bit rg, input bit wp, input logic [21:0] addr,
                           input logic [7:0] len, input bit rwds,
                           output logic [2:0][15:0] ca_obs, output int n_rv, output int n_wr,
                           output bit got_err, output logic [15:0] first_dq);
        bit          ok;
        int          len_eff, n_lat, d0, e;
        bit          exp_err;
        logic [47:0] ca;
        logic [7:0]  exp_ctrl, obs_ctrl;
        bit          wwin, rwin, exp_rv;

        n_rv = 0; n_wr = 0; got_err = 1'b0; first_dq = '0; ca_obs = '0;
        len_eff = (rg && wr) ? 1 : ((len == 8'd0) ? 256 : int'(len));
        n_lat   = (rg && wr) ? 0 : (rwds ? 2 * LATENCY : LATENCY);
        d0      = 3 + n_lat;
        exp_err = 1'b0;
        ca      = {~wr, rg, ~wp, 10'd0, addr[21:3], 13'd0, addr[2:0]};
        if (wr) begin
            e = d0 + len_eff;
        end else begin
            int left, miss, k;
            left = len_eff; miss = 0; k = 0; e = -1;
            while (e < 0) begin
                if (vbit(k)) begin
                    left--; miss = 0;
                    if (left == 0) e = d0 + k + 1;
                end else begin
                    miss++;
                    if (miss == RD_TIMEOUT) begin e = d0 + k + 1; exp_err = 1'b1; end
                end
                k++;
            end
        end
        checks++;
        if (e + T_RWR >= MAXC) begin
            errors++;
            $display("FAIL txn_length: end cycle %0d exceeds bench window %0d", e, MAXC);
            return;
        end

        bus.rwds_in = rwds;
        start_req(wr, rg, wp, addr, len, ok);
        if (!ok) return;

        for (int t = 0; t <= e + T_RWR; t++) begin
            @(negedge clk);
            wwin = wr && t >= d0 && t < e;
            rwin = !wr && t >= d0 && t < e;
            exp_rv = !wr && t >= 1 && (t - 1) >= d0 && (t - 1) < e && vbit(t - 1 - d0);
            bus.req_valid   = 1'b0;
            bus.wdata       = wd[t];
            bus.wmask       = wm[t];
            bus.dq_in       = din[t];
            bus.dq_in_valid = rwin ? vbit(t - d0) : 1'($urandom_range(0, 1));
            #1;
            exp_ctrl = {t >= e, t < e, (t < 3) || wwin, wwin && !rg, wwin,
                        t >= e + T_RWR, t == e, exp_rv};
            obs_ctrl = {bus.cs_n, bus.ck_en, bus.dq_oe, bus.rwds_oe, bus.wdata_ready,
                        bus.req_ready, bus.done, bus.rdata_valid};
            checks++;
            if (obs_ctrl !== exp_ctrl) begin
                errors++;
                $display("FAIL ctrl t=%0d: {cs_n,ck_en,dq_oe,rwds_oe,wdata_ready,req_ready,done,rdata_valid} got %b expected %b",
                         t, obs_ctrl, exp_ctrl);
            end
            if (t < 3) begin
                ca_obs[t] = bus.dq_out;
                checks++;
                if (bus.dq_out !== ca[47 - 16 * t -: 16]) begin
                    errors++;
                    $display("FAIL ca_word%0d: dq_out got %h expected %h", t, bus.dq_out, ca[47 - 16 * t -: 16]);
                end
            end
            if (wwin) begin
                checks++;
                if (bus.dq_out !== wd[t]) begin
                    errors++;
                    $display("FAIL wdata t=%0d: dq_out got %h expected %h", t, bus.dq_out, wd[t]);
                end
                if (!rg) begin
                    checks++;
                    if (bus.rwds_out !== wm[t]) begin
                        errors++;
                        $display("FAIL wmask t=%0d: rwds_out got %b expected %b", t, bus.rwds_out, wm[t]);
                    end
                end
            end
            if (exp_rv) begin
                checks++;
                if (bus.rdata !== din[t - 1]) begin
                    errors++;
                    $display("FAIL rdata t=%0d: rdata got %h expected %h", t, bus.rdata, din[t - 1]);
                end
            end
            if (t == e) begin
                got_err = bus.err;
                checks++;
                if (bus.err !== exp_err) begin
                    errors++;
                    $display("FAIL err_flag: err got %b expected %b", bus.err, exp_err);
                end
            end
            if (bus.wdata_ready === 1'b1) begin
                if (n_wr == 0) first_dq = bus.dq_out;
                n_wr++;
            end
            if (bus.rdata_valid === 1'b1) n_rv++;
        end
        bus.rwds_in = 1'b0;
    endtask

    task automatic test_reset();
        logic [9:0] obs;
        repeat (3) @(negedge clk);
        #1;
        obs = {bus.cs_n, bus.ck_en, bus.dq_oe, bus.rwds_oe, bus.req_ready, bus.wdata_ready,
               bus.rdata_valid, bus.done, bus.err, 1'b0};
        checks++;
        if (obs !== 10'b1000000000 || bus.dq_out !== 16'h0 || bus.rwds_out !== 2'b00) begin
            errors++;
            $display("FAIL reset_outputs: ctrl %b dq_out %h rwds_out %b, expected 1000000000/0000/00",
                     obs, bus.dq_out, bus.rwds_out);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i <= T_RWR; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            checks++;
            if (bus.req_ready !== (i == T_RWR)) begin
                errors++;
                $display("FAIL reset_recovery i=%0d: req_ready got %b expected %b", i, bus.req_ready, i == T_RWR);
            end
        end
    endtask

    task automatic test_read_id0();
        logic [2:0][15:0] ca; int n_rv, n_wr; bit ge; logic [15:0] fd;
        fill_random();
        vpat.delete(); vpat.push_back(1'b0); vpat.push_back(1'b0); vpat.push_back(1'b1);
        run_txn(1'b0, 1'b1, 1'b1, 22'h000000, 8'd1, 1'b0, ca, n_rv, n_wr, ge, fd);
        checks++;
        if (ca !== {16'h0000, 16'h0000, 16'hC000}) begin
            errors++;
            $display("FAIL id0_ca: got %h expected C000/0000/0000 (word0 in low bits)", ca);
        end
        checks++;
        if (n_rv !== 1 || ge !== 1'b0) begin
            errors++;
            $display("FAIL id0_result: rdata_valid count %0d err %b, expected 1 and 0", n_rv, ge);
        end
    endtask

    task automatic test_write_cr0();
        logic [2:0][15:0] ca; int n_rv, n_wr; bit ge; logic [15:0] fd;
        fill_random();
        wd[3] = 16'h8F2B;
        run_txn(1'b1, 1'b1, 1'b0, 22'h000800, 8'd7, 1'b1, ca, n_rv, n_wr, ge, fd);
        checks++;
        if (ca !== {16'h0000, 16'h0100, 16'h6000}) begin
            errors++;
            $display("FAIL cr0_ca: got %h expected 6000/0100/0000 (word0 in low bits)", ca);
        end
        checks++;
        if (n_wr !== 1 || fd !== 16'h8F2B) begin
            errors++;
            $display("FAIL cr0_data: words %0d value %h, expected 1 word of 8F2B", n_wr, fd);
        end
    endtask

    task automatic test_linear_write();
        logic [2:0][15:0] ca; int n_rv, n_wr; bit ge; logic [15:0] fd;
        fill_random();
        run_txn(1'b1, 1'b0, 1'b0, 22'h000000, 8'd40, 1'b1, ca, n_rv, n_wr, ge, fd);
        checks++;
        if (ca[0] !== 16'h2000 || n_wr !== 40) begin
            errors++;
            $display("FAIL linear_write: CA0 %h words %0d, expected 2000 and 40", ca[0], n_wr);
        end
    endtask

    task automatic test_wrap_read();
        logic [2:0][15:0] ca; int n_rv, n_wr; bit ge; logic [15:0] fd;
        fill_random();
        vpat.delete();
        for (int i = 0; i < 32; i++) begin vpat.push_back(1'b1); vpat.push_back(1'b0); end
        run_txn(1'b0, 1'b0, 1'b1, 22'h000005, 8'd32, 1'b0, ca, n_rv, n_wr, ge, fd);
        checks++;
        if (ca !== {16'h0005, 16'h0000, 16'h8000} || n_rv !== 32) begin
            errors++;
            $display("FAIL wrap_read: CA %h words %0d, expected 8000/0000/0005 and 32", ca, n_rv);
        end
    endtask

    task automatic test_timeout();
        logic [2:0][15:0] ca; int n_rv, n_wr; bit ge; logic [15:0] fd;
        fill_random();
        vpat.delete(); vpat.push_back(1'b1); vpat.push_back(1'b1);
        run_txn(1'b0, 1'b0, 1'b0, 22'h012345, 8'd4, 1'b0, ca, n_rv, n_wr, ge, fd);
        checks++;
        if (ge !== 1'b1 || n_rv !== 2) begin
            errors++;
            $display("FAIL timeout: err %b words %0d, expected 1 and 2", ge, n_rv);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [7:0] obs;
        logic [2:0][15:0] ca; int n_rv, n_wr; bit ge; logic [15:0] fd;
        fill_random();
        bus.rwds_in = 1'b0;
        start_req(1'b1, 1'b0, 1'b0, 22'h001234, 8'd128, ok);
        if (!ok) return;
        for (int t = 0; t <= 20; t++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            bus.wdata     = wd[t];
            bus.wmask     = wm[t];
            #1;
        end
        checks++;
        if (bus.wdata_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_burst_active: wdata_ready got %b expected 1", bus.wdata_ready);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        obs = {bus.cs_n, bus.ck_en, bus.dq_oe, bus.rwds_oe, bus.wdata_ready, bus.done, bus.err, bus.rdata_valid};
        checks++;
        if (obs !== 8'b10000000 || bus.dq_out !== 16'h0 || bus.rwds_out !== 2'b00) begin
            errors++;
            $display("FAIL mid_reset_outputs: ctrl %b dq_out %h rwds_out %b, expected 10000000/0000/00",
                     obs, bus.dq_out, bus.rwds_out);
        end
        for (int i = 0; i <= T_RWR; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            checks++;
            if (bus.req_ready !== (i == T_RWR) || bus.cs_n !== 1'b1) begin
                errors++;
                $display("FAIL mid_reset_recovery i=%0d: req_ready %b cs_n %b, expected %b and 1",
                         i, bus.req_ready, bus.cs_n, i == T_RWR);
            end
        end
        fill_random();
        make_reads(5, 2);
        run_txn(1'b0, 1'b0, 1'b0, 22'h2ABCDE, 8'd5, 1'b1, ca, n_rv, n_wr, ge, fd);
        checks++;
        if (n_rv !== 5) begin
            errors++;
            $display("FAIL post_reset_read: words %0d expected 5", n_rv);
        end
    endtask

    // Back-to-back random requests covering every request field and read gaps.
    task automatic test_random();
        logic [2:0][15:0] ca; int n_rv, n_wr; bit ge; logic [15:0] fd;
        bit wr, rg, wp, rwds;
        logic [21:0] addr;
        logic [7:0]  len;
        int words;
        for (int n = 0; n < 30; n++) begin
            wr   = 1'($urandom_range(0, 1));
            rg   = ($urandom_range(0, 3) == 0);
            wp   = 1'($urandom_range(0, 1));
            rwds = 1'($urandom_range(0, 1));
            addr = 22'($urandom);
            len  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 24));
            words = (len == 8'd0) ? 256 : int'(len);
            fill_random();
            if ($urandom_range(0, 4) == 0) make_reads($urandom_range(0, words - 1), 2);
            else make_reads(words, 2);
            run_txn(wr, rg, wp, addr, len, rwds, ca, n_rv, n_wr, ge, fd);
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_read_id0();
        test_write_cr0();
        test_linear_write();
        test_wrap_read();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end
endmodule
